// File: rtl/hour_counter_if.sv
// ============================================================================
//  Module      : hour_counter_if
//  Description : Bus bundle for the BCD hour counter: run/set controls in,
//                BCD hour and day carry out. The 12h display view is only
//                present when HOUR_12H_DISPLAY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hour_counter_if;
    logic       enable;
    logic       hr_inc;
    logic       set_mode;
    logic       set_up;
    logic       set_down;
    logic [3:0] hr_low;
    logic [1:0] hr_high;
    logic       day_inc;
`ifdef HOUR_12H_DISPLAY_EN
    logic [3:0] disp_low;
    logic [1:0] disp_high;
    logic [0:0] pm;
`endif

    // Driver side: clock datapath / testbench
    modport master (
        output enable, hr_inc, set_mode, set_up, set_down,
        input  hr_low, hr_high, day_inc
`ifdef HOUR_12H_DISPLAY_EN
        , disp_low, disp_high, pm
`endif
    );

    // Counter side
    modport slave (
        input  enable, hr_inc, set_mode, set_up, set_down,
        output hr_low, hr_high, day_inc
`ifdef HOUR_12H_DISPLAY_EN
        , disp_low, disp_high, pm
`endif
    );
endinterface

`default_nettype wire

// File: rtl/hour_counter.sv
// ============================================================================
//  Module      : hour_counter
//  Description : BCD hour counter 00..23 with day carry on 23->00 and a
//                manual set mode (up/down buttons, hold-to-auto-repeat).
//                Optional macro HOUR_12H_DISPLAY_EN adds a registered 12h
//                view (disp_low, disp_high, pm) of the hour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_counter #(
    parameter int RESET_HOUR    = 0,
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hour_counter_if.slave bus
);

    // Hold/repeat counter only has to reach the larger of the two limits
    localparam int c_CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_HOLD     = c_CW'(HOLD_CYCLES);
    localparam logic [c_CW-1:0] c_REPEAT   = c_CW'(REPEAT_CYCLES);
    localparam logic [3:0]      c_RST_LOW  = 4'(RESET_HOUR % 10);
    localparam logic [1:0]      c_RST_HIGH = 2'(RESET_HOUR / 10);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_hr_low;
    logic [1:0]      r_hr_high;
    logic            r_day_inc;
    logic            r_up_prev;
    logic            r_dn_prev;
    logic            r_hold_act;
    logic            r_rpt;
    logic [c_CW-1:0] r_cnt;

    logic            w_is_23;
    logic            w_is_00;
    logic [3:0]      w_inc_low;
    logic [1:0]      w_inc_high;
    logic [3:0]      w_dec_low;
    logic [1:0]      w_dec_high;
    logic            w_up_only;
    logic            w_dn_only;
    logic            w_up_edge;
    logic            w_dn_edge;
    logic            w_in_set;
    logic [c_CW-1:0] w_cnt_inc;
    logic [c_CW-1:0] w_limit;
    logic            w_hold_hit;
    logic            w_step_up;
    logic            w_step_dn;
    logic            w_run_inc;
    logic            w_day_wrap;
    logic [3:0]      w_nxt_low;
    logic [1:0]      w_nxt_high;

    assign w_is_23 = (r_hr_high == 2'd2) && (r_hr_low == 4'd3);
    assign w_is_00 = (r_hr_high == 2'd0) && (r_hr_low == 4'd0);

    // BCD +1 and -1 of the current hour, both wrapping inside 00..23
    always_comb begin
        w_inc_low  = r_hr_low + 4'd1;
        w_inc_high = r_hr_high;
        if (w_is_23) begin
            w_inc_low  = 4'd0;
            w_inc_high = 2'd0;
        end else if (r_hr_low == 4'd9) begin
            w_inc_low  = 4'd0;
            w_inc_high = r_hr_high + 2'd1;
        end

        w_dec_low  = r_hr_low - 4'd1;
        w_dec_high = r_hr_high;
        if (w_is_00) begin
            w_dec_low  = 4'd3;
            w_dec_high = 2'd2;
        end else if (r_hr_low == 4'd0) begin
            w_dec_low  = 4'd9;
            w_dec_high = r_hr_high - 2'd1;
        end
    end

    // A press counts only when the other button is released; the edge
    // registers follow the buttons in both states so a button held across
    // a RUN<->SET switch never looks like a fresh press.
    assign w_up_only  = bus.set_up & ~bus.set_down;
    assign w_dn_only  = bus.set_down & ~bus.set_up;
    assign w_up_edge  = w_up_only & ~r_up_prev;
    assign w_dn_edge  = w_dn_only & ~r_dn_prev;
    assign w_in_set   = (r_state == ST_SET) & bus.set_mode;
    assign w_cnt_inc  = r_cnt + c_CW'(1);
    assign w_limit    = r_rpt ? c_REPEAT : c_HOLD;
    assign w_hold_hit = r_hold_act & (w_up_only | w_dn_only) & ~w_up_edge & ~w_dn_edge
                      & (w_cnt_inc == w_limit);
    assign w_step_up  = w_in_set & (w_up_edge | (w_hold_hit & w_up_only));
    assign w_step_dn  = w_in_set & (w_dn_edge | (w_hold_hit & w_dn_only));
    assign w_run_inc  = (r_state == ST_RUN) & bus.hr_inc;
    assign w_day_wrap = w_run_inc & w_is_23;

    // Next hour value: carry in RUN, button steps in SET, otherwise hold
    always_comb begin
        w_nxt_low  = r_hr_low;
        w_nxt_high = r_hr_high;
        if (w_run_inc || w_step_up) begin
            w_nxt_low  = w_inc_low;
            w_nxt_high = w_inc_high;
        end else if (w_step_dn) begin
            w_nxt_low  = w_dec_low;
            w_nxt_high = w_dec_high;
        end
    end

    // RUN/SET state machine with hour, carry and hold/repeat bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_hr_low   <= c_RST_LOW;
            r_hr_high  <= c_RST_HIGH;
            r_day_inc  <= 1'b0;
            r_up_prev  <= 1'b0;
            r_dn_prev  <= 1'b0;
            r_hold_act <= 1'b0;
            r_rpt      <= 1'b0;
            r_cnt      <= '0;
        end else if (bus.enable) begin
            r_up_prev <= bus.set_up;
            r_dn_prev <= bus.set_down;
            r_hr_low  <= w_nxt_low;
            r_hr_high <= w_nxt_high;
            r_day_inc <= w_day_wrap;
            case (r_state)
                ST_RUN: begin
                    if (bus.set_mode) begin
                        r_state <= ST_SET;
                    end
                    r_hold_act <= 1'b0;
                    r_rpt      <= 1'b0;
                    r_cnt      <= '0;
                end
                ST_SET: begin
                    if (!bus.set_mode) begin
                        r_state    <= ST_RUN;
                        r_hold_act <= 1'b0;
                        r_rpt      <= 1'b0;
                        r_cnt      <= '0;
                    end else if (w_up_edge || w_dn_edge) begin
                        // Fresh press: start timing the hold from this cycle
                        r_hold_act <= 1'b1;
                        r_rpt      <= 1'b0;
                        r_cnt      <= '0;
                    end else if (r_hold_act && (w_up_only || w_dn_only)) begin
                        if (w_cnt_inc == w_limit) begin
                            r_rpt <= 1'b1;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        // Released, both pressed, or held without a fresh edge
                        r_hold_act <= 1'b0;
                        r_rpt      <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
            endcase
        end else begin
            r_day_inc <= 1'b0;
        end
    end

    assign bus.hr_low  = r_hr_low;
    assign bus.hr_high = r_hr_high;
    assign bus.day_inc = r_day_inc;

`ifdef HOUR_12H_DISPLAY_EN
    // Maps a BCD 24h hour to {pm, tens[1:0], units[3:0]} of the 12h view
    function automatic logic [6:0] f_to_12h(input logic [1:0] h, input logic [3:0] l);
        logic [4:0] v;
        logic [4:0] v12;
        logic       hi;
        v = (5'(h) * 5'd10) + 5'(l);
        if (v == 5'd0) begin
            v12 = 5'd12;
        end else if (v > 5'd12) begin
            v12 = v - 5'd12;
        end else begin
            v12 = v;
        end
        hi = (v12 >= 5'd10);
        return {(v >= 5'd12), {1'b0, hi}, 4'(hi ? (v12 - 5'd10) : v12)};
    endfunction

    localparam logic [6:0] c_RST_DISP = f_to_12h(c_RST_HIGH, c_RST_LOW);

    logic [6:0] r_disp;

    // 12h view registered from the same next-hour value as hr_low/hr_high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp <= c_RST_DISP;
        end else if (bus.enable) begin
            r_disp <= f_to_12h(w_nxt_high, w_nxt_low);
        end
    end

    assign bus.disp_low  = r_disp[3:0];
    assign bus.disp_high = r_disp[5:4];
    assign bus.pm        = r_disp[6:6];
`endif

endmodule

`default_nettype wire

// File: tb/tb_hour_counter.sv
// ============================================================================
//  Module      : tb_hour_counter
//  Description : Scoreboard bench for hour_counter. The driver applies one
//                input vector per clock and queues the hand-computed hour
//                and carry expected after that edge; the monitor pops and
//                compares after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hour_counter;

    typedef struct {
        string nm;
        int    hr;
        bit    day;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t e_mon;

    int hold_up_exp[11] = '{6, 6, 6, 6, 7, 7, 8, 8, 9, 9, 10};
    int hold_dn_exp[11] = '{19, 19, 19, 19, 18, 18, 17, 17, 16, 16, 15};

    hour_counter_if u_if ();
    hour_counter_if u_if13 ();

    hour_counter #(
        .RESET_HOUR   (0),
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    hour_counter #(
        .RESET_HOUR   (13),
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) u_dut13 (
        .clk(clk),
        .rst(rst),
        .bus(u_if13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd(input int h);
        return ((h / 10) * 16) + (h % 10);
    endfunction

    function automatic int h12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // One clock of stimulus; the expectation is for the outputs after the next edge
    task automatic cyc(input string nm, input bit rstv, input bit en, input bit inc,
                       input bit mode, input bit up, input bit dn,
                       input int exp_hr, input bit exp_day);
        exp_t e;
        @(negedge clk);
        rst             = rstv;
        u_if.enable     = en;
        u_if.hr_inc     = inc;
        u_if.set_mode   = mode;
        u_if.set_up     = up;
        u_if.set_down   = dn;
        e.nm  = nm;
        e.hr  = exp_hr;
        e.day = exp_day;
        sb.push_back(e);
    endtask

    task automatic run(input string nm, input bit inc, input int exp_hr, input bit exp_day);
        cyc(nm, 1'b1, 1'b1, inc, 1'b0, 1'b0, 1'b0, exp_hr, exp_day);
    endtask

    task automatic setc(input string nm, input bit up, input bit dn, input int exp_hr);
        cyc(nm, 1'b1, 1'b1, 1'b0, 1'b1, up, dn, exp_hr, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation after each edge
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            chk({e_mon.nm, "_hr"}, int'({u_if.hr_high, u_if.hr_low}), bcd(e_mon.hr));
            chk({e_mon.nm, "_day"}, int'(u_if.day_inc), int'(e_mon.day));
`ifdef HOUR_12H_DISPLAY_EN
            chk({e_mon.nm, "_disp"}, int'({u_if.disp_high, u_if.disp_low}), bcd(h12(e_mon.hr)));
            chk({e_mon.nm, "_pm"}, int'(u_if.pm), (e_mon.hr >= 12) ? 1 : 0);
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        u_if.enable = 1'b0; u_if.hr_inc = 1'b0; u_if.set_mode = 1'b0;
        u_if.set_up = 1'b0; u_if.set_down = 1'b0;
        u_if13.enable = 1'b0; u_if13.hr_inc = 1'b0; u_if13.set_mode = 1'b0;
        u_if13.set_up = 1'b0; u_if13.set_down = 1'b0;

        // Reset values
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        chk("rst13_hr", int'({u_if13.hr_high, u_if13.hr_low}), 'h13);
        chk("rst13_day", int'(u_if13.day_inc), 0);
`ifdef HOUR_12H_DISPLAY_EN
        chk("rst13_disp", int'({u_if13.disp_high, u_if13.disp_low}), 'h01);
        chk("rst13_pm", int'(u_if13.pm), 1);
`endif
        run("idle", 1'b0, 0, 1'b0);

        // RUN carries, including BCD tens carries
        for (int i = 1; i <= 9; i++) run("run_inc", 1'b1, i, 1'b0);
        run("run_09_10", 1'b1, 10, 1'b0);
        for (int i = 11; i <= 19; i++) run("run_inc", 1'b1, i, 1'b0);
        run("run_19_20", 1'b1, 20, 1'b0);
        run("run_inc", 1'b1, 21, 1'b0);
        run("run_inc", 1'b1, 22, 1'b0);

        // Clock enable low: carry pulses are lost
        for (int i = 0; i < 3; i++)
            cyc("en0_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22, 1'b0);

        // Day rollover with a single-cycle carry
        run("run_inc", 1'b1, 23, 1'b0);
        run("run_23_00", 1'b1, 0, 1'b1);
        run("day_one_cycle", 1'b0, 0, 1'b0);

        // SET mode: edge steps, wraps, both buttons, dropped carry
        setc("enter_set", 1'b0, 1'b0, 0);
        setc("set_dn_wrap", 1'b0, 1'b1, 23);
        setc("set_release", 1'b0, 1'b0, 23);
        setc("set_up_wrap", 1'b1, 1'b0, 0);
        setc("set_release", 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) setc("set_both", 1'b1, 1'b1, 0);
        setc("set_release", 1'b0, 1'b0, 0);
        cyc("set_hrinc_drop", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc("set_hrinc_drop", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Step up to 05, then hold up: edge, hold step, repeat steps
        for (int i = 1; i <= 5; i++) begin
            setc("set_up_edge", 1'b1, 1'b0, i);
            setc("set_release", 1'b0, 1'b0, i);
        end
        for (int i = 0; i < 11; i++) setc("hold_up", 1'b1, 1'b0, hold_up_exp[i]);
        for (int i = 0; i < 4; i++) setc("hold_release", 1'b0, 1'b0, 10);

        // Borrow 10->09, up to 20, borrow 20->19
        setc("borrow_10_09", 1'b0, 1'b1, 9);
        setc("set_release", 1'b0, 1'b0, 9);
        for (int i = 10; i <= 20; i++) begin
            setc("set_up_edge", 1'b1, 1'b0, i);
            setc("set_release", 1'b0, 1'b0, i);
        end
        setc("borrow_20_19", 1'b0, 1'b1, 19);
        setc("set_release", 1'b0, 1'b0, 19);

        // Other button joining a hold cancels it; no resumption without an edge
        setc("hold_other_btn", 1'b1, 1'b0, 20);
        setc("hold_other_btn", 1'b1, 1'b0, 20);
        setc("hold_other_btn", 1'b1, 1'b0, 20);
        for (int i = 0; i < 4; i++) setc("hold_other_btn", 1'b1, 1'b1, 20);
        for (int i = 0; i < 4; i++) setc("hold_other_btn", 1'b1, 1'b0, 20);

        // Hold down from 20 to 15 by auto-repeat
        for (int i = 0; i < 11; i++) setc("hold_dn", 1'b0, 1'b1, hold_dn_exp[i]);

        // Reset in the middle of a hold, then RUN state on release
        cyc("rst_midhold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cyc("rst_midhold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cyc("rst_to_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        cyc("set_after_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        cyc("set_after_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        setc("set_release", 1'b0, 1'b0, 1);
        run("leave_set", 1'b0, 1, 1'b0);
        run("run_after_set", 1'b1, 2, 1'b0);
        run("idle", 1'b0, 2, 1'b0);

        // Every queued expectation must have been consumed by the monitor
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
